// File: rtl/alu_cmd_entry_pkg.sv
// Shared definitions for the ALU command-entry front end: FSM state encodings
// and the packed layout of the ALU flag nibble.
package alu_cmd_entry_pkg;

  localparam logic [2:0] S_A     = 3'd0;
  localparam logic [2:0] S_B     = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SHOW  = 3'd5;

  // Bit order matches the LEDs: LD3=cmp, LD2=ovf, LD1=cin, LD0=zero.
  typedef struct packed {
    logic cmp;
    logic ovf;
    logic cin;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_cmd_entry_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// registered rising-edge pulse (one cycle per press, nothing on release).
module alu_cmd_entry_btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_prev_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked
  // block; every state register uses non-blocking assignment so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
      // Any sample equal to the current level restarts the stability window.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_cmd_entry.sv
// Operator front end for the 4-bit ALU demo: walks the user through A, B and
// opcode entry, issues one valid/ready command and holds the returned result.
module alu_cmd_entry
  import alu_cmd_entry_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int OPW        = 3,
  parameter int DEB_CYCLES = 500000,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next,
  input  logic             btn_back,
  input  logic             btn_clr,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [OPW-1:0]   cmd_select,
  output logic [WIDTH-1:0] cmd_a,
  output logic [WIDTH-1:0] cmd_b,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_result,
  input  logic [3:0]       res_flags,
  output logic [WIDTH-1:0] disp_result,
  output logic [3:0]       disp_flags,
  output logic             err,
  output logic [2:0]       state
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT);

  logic next_p, back_p, clr_p;

  alu_cmd_entry_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .rst(rst), .btn_i(btn_next), .pulse_o(next_p)
  );
  alu_cmd_entry_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
    .clk(clk), .rst(rst), .btn_i(btn_back), .pulse_o(back_p)
  );
  alu_cmd_entry_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst(rst), .btn_i(btn_clr), .pulse_o(clr_p)
  );

  logic [2:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0] disp_res_q, disp_res_d;
  alu_flags_t       disp_flg_q, disp_flg_d;
  logic             err_q, err_d;
  logic [TW-1:0]    wait_q, wait_d;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    disp_res_d = disp_res_q;
    disp_flg_d = disp_flg_q;
    err_d      = err_q;
    wait_d     = wait_q;

    if (clr_p) begin
      state_d    = S_A;
      valid_d    = 1'b0;
      a_d        = '0;
      b_d        = '0;
      sel_d      = '0;
      disp_res_d = '0;
      disp_flg_d = '0;
      err_d      = 1'b0;
      wait_d     = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (next_p) begin
            a_d     = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (back_p) begin
            state_d = S_A;
          end else if (next_p) begin
            b_d     = sw;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (back_p) begin
            state_d = S_B;
          end else if (next_p) begin
            sel_d   = sw[OPW-1:0];
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Operands are frozen here; only the handshake moves us on.
          if (cmd_ready) begin
            valid_d = 1'b0;
            wait_d  = '0;
            if (res_valid) begin
              disp_res_d = res_result;
              disp_flg_d = alu_flags_t'(res_flags);
              err_d      = 1'b0;
              state_d    = S_SHOW;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            disp_res_d = res_result;
            disp_flg_d = alu_flags_t'(res_flags);
            err_d      = 1'b0;
            state_d    = S_SHOW;
          end else if (wait_q == WAIT_LIMIT) begin
            disp_res_d = '0;
            disp_flg_d = '0;
            err_d      = 1'b1;
            state_d    = S_SHOW;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (back_p) begin
            state_d = S_OP;
          end else if (next_p) begin
            state_d = S_A;
          end
        end
        default: begin
          state_d = S_A;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      disp_res_q <= '0;
      disp_flg_q <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      disp_res_q <= disp_res_d;
      disp_flg_q <= disp_flg_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_a       = a_q;
  assign cmd_b       = b_q;
  assign cmd_select  = sel_q;
  assign disp_result = disp_res_q;
  assign disp_flags  = disp_flg_q;
  assign err         = err_q;
  assign state       = state_q;

endmodule
